// File: rtl/uart_pkg.sv
// Shared types and helpers for the streaming UART transmitter:
// FSM state encoding, bit-period derivation and parity.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic int bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Even parity over the word, flipped for odd; unused upper bits must be zero.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_stream.sv
// FIFO-buffered UART transmitter with a valid/ready write port; frames go out
// back-to-back while words are queued. Define UART_TX_PARITY_EN for a parity bit.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit, line low
// DATA   | payload bits, LSB first
// PARITY | parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit(s), line high
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e            state, state_next;
  logic [CW-1:0]          baud_cnt, baud_next;
  logic [2:0]             bit_idx, bit_next;
  logic                   stop_idx, stop_next;
  logic [DATA_BITS-1:0]   shifter, shift_next;
  logic [DATA_BITS-1:0]   fifo_data;
  logic                   tx_next, baud_wrap, pop, fifo_empty, fifo_full;

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (in_valid && in_ready),
    .wr_data(in_data),
    .pop    (pop),
    .rd_data(fifo_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign baud_wrap = (baud_cnt == BAUD_LAST);

`ifdef UART_TX_PARITY_EN
  logic parity_reg, parity_next;
  always_comb begin
    parity_next = parity_reg;
    if (pop) parity_next = parity_bit(8'(fifo_data), parity_odd);
  end
`endif

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    stop_next  = stop_idx;
    shift_next = shifter;
    pop        = 1'b0;
    if (state != IDLE) baud_next = baud_wrap ? '0 : baud_cnt + 1'b1;
    case (state)
      IDLE:  if (!fifo_empty) pop = 1'b1;
      START: if (baud_wrap) begin
        state_next = DATA;
        bit_next   = '0;
      end
      DATA: if (baud_wrap) begin
        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
          stop_next = 1'b0;
        end else begin
          bit_next   = bit_idx + 3'd1;
          shift_next = shifter >> 1;
        end
      end
      PARITY: if (baud_wrap) begin
        state_next = STOP;
        stop_next  = 1'b0;
      end
      STOP: if (baud_wrap) begin
        if (stop_idx == LAST_STOP) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_next = IDLE;
        end else begin
          stop_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A pop always starts a fresh frame, including straight out of STOP.
    if (pop) begin
      state_next = START;
      baud_next  = '0;
      shift_next = fifo_data;
    end
  end

  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_reg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shifter  <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      stop_idx <= stop_next;
      shifter  <= shift_next;
      tx       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: two instances (8N1 and 7-bit/2-stop), a frame-schedule
// model checked every cycle, plus literal spot checks at hand-computed cycles.
`timescale 1ns/1ps
module tb_uart_tx_stream;
  localparam int BP    = 10;
  localparam int DEPTH = 4;
  localparam int MAXW  = 64;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [7:0] in_data0 = 8'h00;
  logic [6:0] in_data1 = 7'h00;
  logic       parity_odd = 1'b0;
  logic       in_ready0, in_ready1, tx0, tx1, busy0, busy1;
  logic [2:0] cnt0, cnt1;

  always #5 clk = ~clk;

  uart_tx_stream #(
    .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx(tx0), .busy(busy0), .fifo_count(cnt0)
  );

  uart_tx_stream #(
    .CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx(tx1), .busy(busy1), .fifo_count(cnt1)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: each accepted word gets a scheduled [start, end) window on the line.
  int         nw [2];
  int         acc_e [2][MAXW];
  int         st_e [2][MAXW];
  int         en_e [2][MAXW];
  logic [7:0] wd [2][MAXW];
  logic       wodd [2][MAXW];
  int         last_end [2];
  logic       m_ready [2];
  logic       m_busy [2];
  logic [1:0] try_q = 2'b00;
  logic [7:0] d0_q = 8'h00, d1_q = 8'h00;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    try_q <= {in_valid1 && !rst, in_valid0 && !rst};
    d0_q  <= in_data0;
    d1_q  <= {1'b0, in_data1};
  end

  function automatic int db(input int d);
    return (d == 0) ? 8 : 7;
  endfunction
  function automatic int sb(input int d);
    return (d == 0) ? 1 : 2;
  endfunction
  function automatic int par(input int d);
    return (d == 0) ? 0 : PAR;
  endfunction

  function automatic logic frame_bit(input int d, input int i, input int b);
    logic [7:0] w;
    w = wd[d][i];
    if (b == 0) return 1'b0;
    if (b <= db(d)) return w[b-1];
    if (par(d) == 1 && b == db(d) + 1) return (^w) ^ wodd[d][i];
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic model_step();
    int t, pend, e_cnt, n, s;
    logic e_busy, e_tx;
    t = cyc;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        nw[d] = 0;
        last_end[d] = 0;
      end else if (try_q[d]) begin
        pend = 0;
        for (int i = 0; i < nw[d]; i++) if (st_e[d][i] >= t) pend++;
        if (pend < DEPTH && nw[d] < MAXW) begin
          n = nw[d];
          s = (t + 1 > last_end[d]) ? t + 1 : last_end[d];
          acc_e[d][n] = t;
          st_e[d][n]  = s;
          en_e[d][n]  = s + (1 + db(d) + par(d) + sb(d)) * BP;
          wd[d][n]    = (d == 0) ? d0_q : d1_q;
          wodd[d][n]  = parity_odd;
          last_end[d] = en_e[d][n];
          nw[d]       = n + 1;
        end
      end
      e_cnt = 0; e_busy = 1'b0; e_tx = 1'b1;
      for (int i = 0; i < nw[d]; i++) begin
        if (acc_e[d][i] <= t && st_e[d][i] > t) e_cnt++;
        if (acc_e[d][i] <= t && en_e[d][i] > t) e_busy = 1'b1;
        if (st_e[d][i] <= t && t < en_e[d][i]) e_tx = frame_bit(d, i, (t - st_e[d][i]) / BP);
      end
      m_ready[d] = (e_cnt < DEPTH);
      m_busy[d]  = e_busy;
      check($sformatf("d%0d tx @%0d", d, t), (d == 0) ? tx0 : tx1, e_tx);
      check($sformatf("d%0d busy @%0d", d, t), (d == 0) ? busy0 : busy1, e_busy);
      check($sformatf("d%0d fifo_count @%0d", d, t), (d == 0) ? cnt0 : cnt1, e_cnt);
      check($sformatf("d%0d in_ready @%0d", d, t), (d == 0) ? in_ready0 : in_ready1, m_ready[d]);
    end
  endtask

  initial begin
    nw = '{0, 0};
    last_end = '{0, 0};
    m_ready = '{1'b1, 1'b1};
    m_busy = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // Holds in_valid until the model says the word was taken on a clock edge.
  task automatic send(input int d, input logic [7:0] data);
    logic acc;
    int n;
    if (d == 0) begin in_valid0 = 1'b1; in_data0 = data; end
    else        begin in_valid1 = 1'b1; in_data1 = data[6:0]; end
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      @(posedge clk);
      acc = m_ready[d] && !rst;
      #2;
      n++;
    end
    check($sformatf("d%0d send %0h accepted", d, data), acc, 1'b1);
    if (d == 0) in_valid0 = 1'b0;
    else        in_valid1 = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (m_busy[d] && n < 3000) begin
      tick();
      n++;
    end
    check($sformatf("d%0d idle reached", d), m_busy[d], 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    int k, k1;
    logic [7:0] w6 [6];
    w6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    #1 rst = 1'b1;
    repeat (3) tick();
    check("reset tx", tx0, 1'b1);
    check("reset in_ready", in_ready0, 1'b1);
    check("reset busy", busy0, 1'b0);
    check("reset fifo_count", cnt0, 3'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single 0x55, 8N1.
    send(0, 8'h55);
    k = cyc;
    check("t1 busy on accept", busy0, 1'b1);
    check("t1 tx still idle", tx0, 1'b1);
    wait_until(k + 1);  check("t1 start bit", tx0, 1'b0);
    wait_until(k + 10); check("t1 start end", tx0, 1'b0);
    wait_until(k + 11); check("t1 bit0", tx0, 1'b1);
    wait_until(k + 21); check("t1 bit1", tx0, 1'b0);
    wait_until(k + 100); check("t1 stop", tx0, 1'b1);
    check("t1 busy in stop", busy0, 1'b1);
    wait_until(k + 101); check("t1 busy falls", busy0, 1'b0);
    wait_idle(0);

    // Back-to-back frames, no idle gap.
    send(0, 8'hA3);
    k = cyc;
    check("t2 count after push1", cnt0, 3'd1);
    send(0, 8'h0F);
    check("t2 count push+pop", cnt0, 3'd1);
    wait_until(k + 100); check("t2 stop of frame1", tx0, 1'b1);
    wait_until(k + 101); check("t2 frame2 start", tx0, 1'b0);
    check("t2 count after pop2", cnt0, 3'd0);
    wait_idle(0);

    // FIFO fill with depth 4.
    for (int i = 0; i < 6; i++) begin
      send(0, w6[i]);
      if (i == 0) k = cyc;
      if (i == 4) begin
        check("t3 in_ready low when full", in_ready0, 1'b0);
        check("t3 count full", cnt0, 3'd4);
      end
    end
    check("t3 sixth accept edge", cyc, k + 102);
    wait_idle(0);

    // 7 data bits, 2 stop bits, 0x41.
    parity_odd = 1'b0;
    send(1, 8'h41);
    k = cyc;
    wait_until(k + 11); check("t4 bit0", tx1, 1'b1);
    wait_until(k + 61); check("t4 bit5", tx1, 1'b0);
    wait_until(k + 71); check("t4 bit6", tx1, 1'b1);
`ifdef UART_TX_PARITY_EN
    wait_until(k + 81); check("t4 even parity", tx1, 1'b0);
    wait_until(k + 110); check("t4 busy last stop", busy1, 1'b1);
    wait_until(k + 111); check("t4 busy falls", busy1, 1'b0);
`else
    wait_until(k + 81); check("t4 stop1", tx1, 1'b1);
    wait_until(k + 100); check("t4 busy last stop", busy1, 1'b1);
    wait_until(k + 101); check("t4 busy falls", busy1, 1'b0);
`endif
    wait_idle(1);
    parity_odd = 1'b1;
    send(1, 8'h41);
    k = cyc;
`ifdef UART_TX_PARITY_EN
    wait_until(k + 81); check("t4 odd parity", tx1, 1'b1);
`else
    wait_until(k + 81); check("t4 stop after data", tx1, 1'b1);
`endif
    wait_idle(1);
    parity_odd = 1'b0;

    // Reset in the middle of data bit 3 with two words queued.
    send(0, 8'h00);
    k = cyc;
    send(0, 8'h00);
    send(0, 8'h00);
    wait_until(k + 45);
    check("t5 tx low before reset", tx0, 1'b0);
    check("t5 count before reset", cnt0, 3'd2);
    #1 rst = 1'b1;
    #1;
    check("t5 tx async high", tx0, 1'b1);
    check("t5 busy cleared", busy0, 1'b0);
    check("t5 fifo flushed", cnt0, 3'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send(0, 8'hFF);
    k = cyc;
    wait_until(k + 1); check("t5 start after reset", tx0, 1'b0);
    wait_until(k + 11); check("t5 bit0 of FF", tx0, 1'b1);
    wait_idle(0);

    // Push coinciding with end-of-frame pop at count 2.
    send(0, 8'h3C);
    k = cyc;
    send(0, 8'hC3);
    send(0, 8'h5A);
    check("t6 count two queued", cnt0, 3'd2);
    wait_until(k + 100);
    send(0, 8'h99);
    k1 = cyc;
    check("t6 push edge", k1, k + 101);
    check("t6 count unchanged", cnt0, 3'd2);
    check("t6 frame2 start", tx0, 1'b0);
    wait_idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
